// File: rtl/io_pkg.sv
// io_pkg -- shared definitions for the I/O sequencer.
//   state_t   : FSM state codes, also exported on the debug 'state' port
//   SW_W      : width of the raw switch bank
//   DATA_W    : processor datapath width
//   IN_PAD_W  : zero bits prepended to the switch value on an input instruction
//   zext_sw() : widens a switch sample to a datapath word
package io_pkg;

   localparam int SW_W     = 10;
   localparam int DATA_W   = 32;
   localparam int IN_PAD_W = DATA_W - SW_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_IN = 2'd1,
      RELEASE = 2'd2,
      HALTED  = 2'd3
   } state_t;

   function automatic logic [DATA_W-1:0] zext_sw(input logic [SW_W-1:0] s);
      return {{IN_PAD_W{1'b0}}, s};
   endfunction

endpackage

// File: rtl/debounce.sv
// debounce -- two-flop synchronizer followed by a stability counter.
//   clk   : system clock
//   reset : synchronous, active-high
//   raw   : asynchronous push-button level
//   level : debounced level (registered)
//   press : one-cycle pulse, high in the cycle whose closing edge takes the
//           debounced level from 0 to 1, so a consumer acts on the same edge
module debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int             CNT_W = 20;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   always_comb begin
      // NOTE: every output of this block gets a default before any branch,
      // so no path leaves a signal unassigned and no latch is inferred.
      sync1_d = raw;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      press   = 1'b0;
      // The counter only runs while the synchronized input disagrees with
      // the settled level; one agreeing sample drops it back to zero.
      if (sync2_q != level_q) begin
         if (cnt_q == LAST) begin
            level_d = sync2_q;
            press   = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments in clocked blocks, so every flop
      // samples the pre-edge value of the others regardless of order.
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/io_sequencer.sv
// io_sequencer -- stalls the processor around input/halt instructions and
// latches output-instruction data for the display.
//   CLK, reset          : clock, synchronous active-high reset
//   Enter, sw           : raw push button and switch bank
//   in_req/out_req/
//   halt_req            : instruction decodes from Control, valid this cycle
//   wr_data             : rs operand of an output instruction
//   stall               : combinational freeze of PC and write enables
//   in_data             : zero-extended switch value for input instructions
//   disp_data/disp_valid: latched display value and "ever written" flag
//   halted, state       : halt indicator and debug state code
module io_sequencer
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              Enter,
   input  logic [SW_W-1:0]   sw,
   input  logic              in_req,
   input  logic              out_req,
   input  logic              halt_req,
   input  logic [DATA_W-1:0] wr_data,
   output logic              stall,
   output logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   output logic              halted,
   output logic [1:0]        state
);

   logic enter_level;
   logic enter_press;
   logic enter_rise;

   debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk  (CLK),
      .reset(reset),
      .raw  (Enter),
      .level(enter_level),
      .press(enter_press)
   );

   // A press is only meaningful while the settled level is still low; a pulse
   // is never kept for later, so presses outside WAIT_IN simply vanish.
   assign enter_rise = enter_press & ~enter_level;

   state_t              state_q,      state_d;
   logic [DATA_W-1:0]   in_data_q,    in_data_d;
   logic [DATA_W-1:0]   disp_data_q,  disp_data_d;
   logic                disp_valid_q, disp_valid_d;

   always_comb begin
      state_d      = state_q;
      in_data_d    = in_data_q;
      disp_data_d  = disp_data_q;
      disp_valid_d = disp_valid_q;
      case (state_q)
         IDLE: begin
            if (halt_req) begin
               state_d = HALTED;
            end else if (in_req) begin
               state_d = WAIT_IN;
            end else if (out_req) begin
               disp_data_d  = wr_data;
               disp_valid_d = 1'b1;
            end
         end
         WAIT_IN: begin
            if (enter_rise) begin
               in_data_d = zext_sw(sw);
               state_d   = RELEASE;
            end
         end
         // One unstalled cycle lets the PC move past the input instruction
         // before its decode can be seen again.
         RELEASE: state_d = IDLE;
         HALTED:  state_d = HALTED;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q      <= IDLE;
         in_data_q    <= '0;
         disp_data_q  <= '0;
         disp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_data_q    <= in_data_d;
         disp_data_q  <= disp_data_d;
         disp_valid_q <= disp_valid_d;
      end
   end

   // The stall must cover the very cycle the decode appears in IDLE, so it
   // cannot wait for the state register.
   always_comb begin
      stall = 1'b0;
      case (state_q)
         IDLE:    stall = halt_req | in_req;
         WAIT_IN: stall = 1'b1;
         HALTED:  stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   assign in_data    = in_data_q;
   assign disp_data  = disp_data_q;
   assign disp_valid = disp_valid_q;
   assign halted     = (state_q == HALTED);
   assign state      = state_q;

endmodule
